// File: rtl/dram_ctrl_if.sv
// Request/response bus between the system-side bus slave wrapper and the
// DRAM controller. The master issues one word request at a time and the
// slave (dram_ctrl) returns a single-cycle completion pulse.
interface dram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wstrb, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wstrb, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dram_ctrl.sv
// Single-port DRAM controller: turns one-at-a-time word requests into
// ACT / CAS / PRE command sequences on the DRAM pins, with programmable
// T_RP, T_RCD and T_WR spacing (each 1..15, 4-bit counters).
// Optional feature: define DRAMC_OPEN_PAGE_EN to keep the row open after an
// access (row hit goes straight to CAS, row miss precharges first).
module dram_ctrl #(
  parameter int unsigned T_RP  = 5,
  parameter int unsigned T_RCD = 5,
  parameter int unsigned T_WR  = 5
) (
  input  logic              clk,
  input  logic              rst,
  dram_ctrl_if.slave        bus,
  output logic              DRAM_CSn,
  output logic              DRAM_RASn,
  output logic              DRAM_CASn,
  output logic [3:0]        DRAM_WEn,
  output logic [10:0]       DRAM_A,
  output logic [31:0]       DRAM_D,
  input  logic [31:0]       DRAM_Q,
  input  logic              DRAM_valid
);

  typedef enum logic [3:0] {
    IDLE, PRE, PRE_WAIT, ACT, RCD_WAIT, COL, RD_WAIT, RESP, WR_WAIT
  } state_t;

`ifdef DRAMC_OPEN_PAGE_EN
  localparam state_t AFTER_ACCESS = IDLE;
`else
  localparam state_t AFTER_ACCESS = PRE;
`endif

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        pend;
  logic        accept;

  logic        lat_write;
  logic [10:0] lat_row;
  logic [9:0]  lat_col;
  logic [3:0]  lat_wstrb;
  logic [31:0] lat_wdata;

  logic        cur_write;
  logic [10:0] cur_row;
  logic [9:0]  cur_col;
  logic [3:0]  cur_wstrb;
  logic [31:0] cur_wdata;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[31:23], bus.req_addr[1:0]};

  assign accept = (state == IDLE) && bus.req_ready && bus.req_valid;

  // The first command is issued on the accept edge, before the request
  // registers are loaded, so in IDLE the bus fields are used directly.
  always_comb begin
    cur_write = lat_write;
    cur_row   = lat_row;
    cur_col   = lat_col;
    cur_wstrb = lat_wstrb;
    cur_wdata = lat_wdata;
    if (state == IDLE) begin
      cur_write = bus.req_write;
      cur_row   = bus.req_addr[22:12];
      cur_col   = bus.req_addr[11:2];
      cur_wstrb = bus.req_wstrb;
      cur_wdata = bus.req_wdata;
    end
  end

`ifdef DRAMC_OPEN_PAGE_EN
  logic        page_open;
  logic [10:0] open_row;

  // Track which row the device currently has open.
  always_ff @(posedge clk) begin
    if (rst) begin
      page_open <= 1'b0;
      open_row  <= '0;
    end else if (state == ACT) begin
      page_open <= 1'b1;
      open_row  <= lat_row;
    end else if (state == PRE) begin
      page_open <= 1'b0;
    end
  end
`endif

  // Request capture; pend marks a request that has not yet responded, so
  // the end of precharge knows whether to activate or return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      lat_write <= 1'b0;
      lat_row   <= '0;
      lat_col   <= '0;
      lat_wstrb <= '0;
      lat_wdata <= '0;
    end else begin
      if (accept) begin
        pend      <= 1'b1;
        lat_write <= bus.req_write;
        lat_row   <= bus.req_addr[22:12];
        lat_col   <= bus.req_addr[11:2];
        lat_wstrb <= bus.req_wstrb;
        lat_wdata <= bus.req_wdata;
      end else if (state == RESP) begin
        pend <= 1'b0;
      end
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef DRAMC_OPEN_PAGE_EN
          if (page_open && (open_row == cur_row)) state_next = COL;
          else if (page_open)                     state_next = PRE;
          else                                    state_next = ACT;
`else
          state_next = ACT;
`endif
        end
      end
      PRE: begin
        if (T_RP > 1) begin
          state_next = PRE_WAIT;
          cnt_next   = 4'(T_RP - 1);
        end else begin
          state_next = pend ? ACT : IDLE;
        end
      end
      PRE_WAIT: begin
        if (cnt <= 4'd1) state_next = pend ? ACT : IDLE;
        else             cnt_next   = cnt - 4'd1;
      end
      ACT: begin
        if (T_RCD > 1) begin
          state_next = RCD_WAIT;
          cnt_next   = 4'(T_RCD - 1);
        end else begin
          state_next = COL;
        end
      end
      RCD_WAIT: begin
        if (cnt <= 4'd1) state_next = COL;
        else             cnt_next   = cnt - 4'd1;
      end
      COL: state_next = lat_write ? RESP : RD_WAIT;
      RD_WAIT: begin
        if (DRAM_valid) state_next = RESP;
      end
      // RESP is already one cycle past CAS, so WR_WAIT covers the remaining
      // T_WR-2 cycles; short T_WR simply leaves straight from RESP.
      RESP: begin
        if (lat_write && (T_WR > 2)) begin
          state_next = WR_WAIT;
          cnt_next   = 4'(T_WR - 2);
        end else begin
          state_next = AFTER_ACCESS;
        end
      end
      WR_WAIT: begin
        if (cnt <= 4'd1) state_next = AFTER_ACCESS;
        else             cnt_next   = cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered pin and bus outputs, decoded from the state being entered so
  // each command appears in the same cycle as its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      DRAM_CSn       <= 1'b1;
      DRAM_RASn      <= 1'b1;
      DRAM_CASn      <= 1'b1;
      DRAM_WEn       <= '1;
      DRAM_A         <= '0;
      DRAM_D         <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      DRAM_CSn       <= (state_next == IDLE);
      DRAM_RASn      <= !((state_next == PRE) || (state_next == ACT));
      DRAM_CASn      <= !(state_next == COL);
      bus.req_ready  <= (state_next == IDLE);
      bus.resp_valid <= (state_next == RESP);
      DRAM_WEn       <= '1;
      if (state_next == PRE)
        DRAM_WEn <= '0;
      else if ((state_next == COL) && cur_write)
        DRAM_WEn <= ~cur_wstrb;
      if (state_next == ACT)
        DRAM_A <= cur_row;
      else if (state_next == COL)
        DRAM_A <= {1'b0, cur_col};
      if ((state_next == COL) && cur_write)
        DRAM_D <= cur_wdata;
      if ((state == RD_WAIT) && DRAM_valid)
        bus.resp_rdata <= DRAM_Q;
    end
  end

endmodule
